// File: rtl/aes128_key_expander_if.sv
// Key-schedule bus between the AES-128 cipher controller (master) and the
// on-the-fly key expander (slave).
interface aes128_key_expander_if;
  logic [127:0] cipher_key;
  logic         cipher_en;
  logic         rkey_en;
  logic [3:0]   round_num;
  logic [127:0] round_key;
  logic [127:0] last_key;
  logic         last_key_valid;

  modport master (
    output cipher_key, cipher_en, rkey_en, round_num,
    input  round_key, last_key, last_key_valid
  );

  modport slave (
    input  cipher_key, cipher_en, rkey_en, round_num,
    output round_key, last_key, last_key_valid
  );
endinterface

// File: rtl/aes128_key_expander.sv
// On-the-fly AES-128 key schedule: one round key per cycle for the cipher core,
// plus a captured round-10 key for a later inverse cipher.
module aes128_key_expander (
  input  logic                        clk_sys,
  input  logic                        rst_n,
  aes128_key_expander_if.slave        kx
);

  logic [127:0] key_q, key_d;
  logic [127:0] last_key_q, last_key_d;
  logic         last_vld_q, last_vld_d;
  logic         round_ok;
  logic [127:0] round_key;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rn);
    case (rn)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign round_ok = (kx.round_num >= 4'd1) && (kx.round_num <= 4'd10);

  always_comb begin
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = key_q[127:96];
    w1 = key_q[95:64];
    w2 = key_q[63:32];
    w3 = key_q[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(kx.round_num), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    round_key = round_ok ? {n0, n1, n2, n3} : key_q;
  end

  // A start pulse wins over an in-flight round so a restart discards the partial schedule.
  always_comb begin
    key_d      = key_q;
    last_key_d = last_key_q;
    last_vld_d = last_vld_q;
    if (kx.cipher_en) begin
      key_d      = kx.cipher_key;
      last_vld_d = 1'b0;
    end else if (kx.rkey_en && round_ok) begin
      key_d = round_key;
      if (kx.round_num == 4'd10) begin
        last_key_d = round_key;
        last_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      last_key_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      key_q      <= key_d;
      last_key_q <= last_key_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign kx.round_key      = round_key;
  assign kx.last_key       = last_key_q;
  assign kx.last_key_valid = last_vld_q;

endmodule

// File: tb/tb_aes128_key_expander.sv
// Directed bench for the AES-128 key expander using FIPS-197 key schedules.
module tb_aes128_key_expander;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  aes128_key_expander_if kx ();

  aes128_key_expander dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .kx      (kx.slave)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [3:0]   rn;
    logic [127:0] exp;
  } vec_t;

  vec_t fips[10];

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_SEQ   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K10_SEQ  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load(input logic [127:0] key);
    kx.cipher_key = key;
    kx.cipher_en  = 1'b1;
    kx.rkey_en    = 1'b0;
    kx.round_num  = 4'd0;
    tick();
    kx.cipher_en  = 1'b0;
  endtask

  task automatic idle();
    kx.rkey_en   = 1'b0;
    kx.round_num = 4'd0;
    #1;
  endtask

  initial begin
    fips[0] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips[1] = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips[2] = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips[3] = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips[4] = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips[5] = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips[6] = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips[7] = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips[8] = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips[9] = '{4'd10, K10_FIPS};

    kx.cipher_key = '0;
    kx.cipher_en  = 1'b0;
    kx.rkey_en    = 1'b0;
    kx.round_num  = 4'd0;

    // Power-on reset
    repeat (2) tick();
    chk("rst_last_key", kx.last_key, '0);
    chk("rst_valid", {127'd0, kx.last_key_valid}, '0);
    chk("rst_round_key", kx.round_key, '0);
    rst_n = 1'b1;
    tick();

    // Full FIPS-197 schedule, table driven
    load(KEY_FIPS);
    for (int i = 0; i < 10; i++) begin
      kx.rkey_en   = 1'b1;
      kx.round_num = fips[i].rn;
      #1;
      chk($sformatf("fips_rk%0d", fips[i].rn), kx.round_key, fips[i].exp);
      chk($sformatf("fips_valid_r%0d", fips[i].rn), {127'd0, kx.last_key_valid}, '0);
      tick();
    end
    idle();
    chk("fips_last_key", kx.last_key, K10_FIPS);
    chk("fips_valid", {127'd0, kx.last_key_valid}, 128'd1);
    chk("fips_key_reg", kx.round_key, K10_FIPS);

    // Idle hold for 20 cycles, then a new start clears the valid flag
    repeat (20) tick();
    chk("idle_key_reg", kx.round_key, K10_FIPS);
    chk("idle_last_key", kx.last_key, K10_FIPS);
    chk("idle_valid", {127'd0, kx.last_key_valid}, 128'd1);
    load(KEY_FIPS);
    idle();
    chk("reload_valid", {127'd0, kx.last_key_valid}, '0);
    chk("reload_last_key", kx.last_key, K10_FIPS);
    chk("reload_key_reg", kx.round_key, KEY_FIPS);

    // Async reset mid-operation at round 5
    for (int i = 0; i < 4; i++) begin
      kx.rkey_en   = 1'b1;
      kx.round_num = fips[i].rn;
      tick();
    end
    kx.round_num = 4'd5;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_last_key", kx.last_key, '0);
    chk("midrst_valid", {127'd0, kx.last_key_valid}, '0);
    idle();
    chk("midrst_key_reg", kx.round_key, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_round_key", kx.round_key, '0);

    // Second full run with the sequential key, checking first and last rounds
    load(KEY_SEQ);
    for (int r = 1; r <= 10; r++) begin
      kx.rkey_en   = 1'b1;
      kx.round_num = 4'(r);
      #1;
      if (r == 1)  chk("seq_rk1", kx.round_key, K1_SEQ);
      if (r == 10) chk("seq_rk10", kx.round_key, K10_SEQ);
      tick();
    end
    idle();
    chk("seq_last_key", kx.last_key, K10_SEQ);
    chk("seq_valid", {127'd0, kx.last_key_valid}, 128'd1);

    // Restart at round 6 of the FIPS key with the sequential key
    load(KEY_FIPS);
    for (int i = 0; i < 5; i++) begin
      kx.rkey_en   = 1'b1;
      kx.round_num = fips[i].rn;
      tick();
    end
    kx.rkey_en    = 1'b1;
    kx.round_num  = 4'd6;
    kx.cipher_key = KEY_SEQ;
    kx.cipher_en  = 1'b1;
    #1;
    chk("restart_rk6", kx.round_key, fips[5].exp);
    tick();
    kx.cipher_en = 1'b0;
    kx.round_num = 4'd0;
    #1;
    chk("restart_key_reg", kx.round_key, KEY_SEQ);
    chk("restart_valid", {127'd0, kx.last_key_valid}, '0);
    for (int r = 1; r <= 10; r++) begin
      kx.round_num = 4'(r);
      #1;
      if (r == 1) chk("restart_rk1", kx.round_key, K1_SEQ);
      tick();
    end
    idle();
    chk("restart_last_key", kx.last_key, K10_SEQ);

    // Illegal rounds with rkey_en high change nothing
    kx.rkey_en   = 1'b1;
    kx.round_num = 4'd0;
    #1;
    chk("illegal0_rk", kx.round_key, K10_SEQ);
    tick();
    kx.round_num = 4'd12;
    #1;
    chk("illegal12_rk", kx.round_key, K10_SEQ);
    tick();
    kx.round_num = 4'd15;
    tick();
    idle();
    chk("illegal_key_reg", kx.round_key, K10_SEQ);
    chk("illegal_last_key", kx.last_key, K10_SEQ);
    chk("illegal_valid", {127'd0, kx.last_key_valid}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_key_expander.md
Name: aes128_key_expander

Overview:
- On-the-fly AES-128 key schedule that sits directly upstream of the AES-128 cipher core.
- Generates one round key per cycle, keyed by the core's `round_num` and `rkey_en`, and drives the core's `round_key` input.
- Also captures the final (round-10) key, with a valid flag, for a later inverse-cipher core that needs it as its starting key.

Parameters:
- None. The block is fixed to AES-128: 10 rounds, 128-bit key.

Ports:
- `clk_sys` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cipher_key` in 128: initial cipher key; sampled only when `cipher_en`=1.
- `cipher_en` in 1: start pulse, same signal the cipher core receives; loads the key register.
- `rkey_en` in 1: round-key enable from the cipher core (high for the whole of an operation).
- `round_num` in 4: round counter from the cipher core, values 1..10 while `rkey_en`=1.
- `round_key` out 128: combinational round key for round `round_num`.
- `last_key` out 128: registered round-10 key of the most recent completed expansion.
- `last_key_valid` out 1: `last_key` holds the key of the current `cipher_key` load.

Behaviour:
- State elements:
  - `key_reg` (128 b): holds round key r-1 while the core is in round r.
  - `last_key` (128 b).
  - `last_key_valid` (1 b).
- Reset (async, `rst_n`=0):
  - `key_reg`=0, `last_key`=0, `last_key_valid`=0.
  - `round_key` therefore follows the combinational rule below from the reset state of `key_reg`.
- Word order: w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0]. Bytes are big-endian within each word.
- Rcon lookup, `round_num` 1..10 -> 01,02,04,08,10,20,40,80,1b,36. Any other `round_num` -> 00.
- Combinational `round_key`, built from `key_reg` = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}. RotWord: {b0,b1,b2,b3}->{b1,b2,b3,b0}. SubWord applies the forward S-box (shared sbox function) to each byte.
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
  - `round_key`={n0,n1,n2,n3} when `round_num` is 1..10. Otherwise `round_key`=`key_reg`, with no expansion.
- Sequential update on each rising edge, in priority order:
  1. `cipher_en`=1: `key_reg`<=`cipher_key`; `last_key_valid`<=0. This applies even if `rkey_en`=1, i.e. a restart mid-operation discards the partial schedule.
  2. else `rkey_en`=1 and `round_num` in 1..10: `key_reg`<=`round_key`.
     - If `round_num`=10, additionally `last_key`<=`round_key` and `last_key_valid`<=1.
  3. else: hold all state.
- Latency and timing relative to the cipher core:
  - The `cipher_en` edge loads key 0. The core XORs `cipher_key` directly in that cycle, so this block plays no part in round 0.
  - In each following cycle with `round_num`=r, `round_key`=K(r), valid with zero latency.
  - After the round-10 edge, `last_key`=K(10) and `last_key_valid`=1 in the next cycle.
- `rkey_en`=1 with `round_num` 0 or 11..15 (illegal): `key_reg` holds and `last_key` is untouched.
- `rkey_en`=0 and `cipher_en`=0: `key_reg` holds, so `round_key` stays stable for inspection.
- `last_key` keeps its value across later idle cycles. Only a completed round 10 overwrites it, and only reset clears it.
- No combinational path from `cipher_key` to `round_key`. `round_key` depends only on `key_reg` and `round_num`.

Test Plan:
1. Reset with `rst_n`=0 asserted mid-operation at round 5 -> immediately `key_reg`=0, `last_key`=0, `last_key_valid`=0. After release with `round_num`=0, `round_key`=0.
2. Pulse `cipher_en` with `cipher_key`=2b7e151628aed2a6abf7158809cf4f3c, then `rkey_en`=1 with `round_num` 1,2,...,10 on successive cycles:
   - `round_num`=1 -> `round_key`=a0fafe1788542cb123a339392a6c7605.
   - `round_num`=2 -> `round_key`=f2c295f27a96b9435935807a7359f67f.
   - `round_num`=10 -> `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Next cycle -> `last_key`=d014f9a8c9ee2589e13f0cc8b6630ca6 and `last_key_valid`=1.
3. Full run with `cipher_key`=000102030405060708090a0b0c0d0e0f -> `last_key`=13111d7fe3944a17f307a78b4d2b30c5. Connected to the cipher core with plaintext 00112233445566778899aabbccddeeff, `cipher_text`=69c4e0d86a7b0430d8cdb780070b4c5a.
4. Restart at `round_num`=6 of the FIPS key: `cipher_en`=1 together with `rkey_en`=1 and new key 000102..0f -> `key_reg` reloads, `last_key_valid`=0, and the following round 1 yields d6aa74fdd2af72fadaa678f1d6ab76fe.
5. Idle hold after a completed run: `rkey_en`=0 for 20 cycles -> `key_reg`, `last_key` and `last_key_valid`=1 all unchanged. Then `cipher_en` -> `last_key_valid` drops to 0 the next cycle.
6. Illegal round: `rkey_en`=1 with `round_num`=0 and then 12 -> `round_key`=`key_reg` and no state change.
